// File: rtl/uart_transmitter.sv
// UART transmit engine: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// Every output is a flop, and each flop loads the value that goes with the next state.
//
//   state  | meaning
//   IDLE   | line high, ready for a byte
//   START  | start bit, line low
//   DATA   | data bits from shift register bit 0
//   PARITY | parity bit (PARITY_EN=1 only)
//   STOP   | STOP_BITS stop bits, line high
`timescale 1ns/1ps
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_INIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = tx_data;
          par_d   = PAR_INIT;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        // Parity accumulates from the bits actually shifted out of the latched byte.
        if (bit_end) begin
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_d;
      default:  serial_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign tx_ready  = ready_q;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: five configurations against a frame-level model, plus directed frames.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int N = 5;
  localparam int CPB  [N] = '{4, 4, 4, 4, 3};
  localparam int DB   [N] = '{8, 8, 8, 8, 5};
  localparam int PEN  [N] = '{0, 1, 1, 0, 1};
  localparam int PODD [N] = '{0, 0, 1, 0, 1};
  localparam int SB   [N] = '{1, 1, 1, 2, 2};

  logic       clk;
  logic       rst;
  logic [7:0] d_data   [N];
  logic       d_valid  [N];
  logic       o_ready  [N];
  logic       o_serial [N];
  logic       o_busy   [N];
  logic       o_done   [N];

  int n_chk;
  int n_err;
  bit chk_en;

  // Model: per configuration, the whole frame as a bit vector in time order plus the cycle index into it.
  logic [15:0] m_f    [N];
  int          m_pos  [N];
  bit          m_busy [N];
  bit          m_done [N];
  int          acc    [N];

  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(rst), .tx_data(d_data[0]), .tx_valid(d_valid[0]),
    .tx_ready(o_ready[0]), .tx_serial(o_serial[0]), .tx_busy(o_busy[0]), .tx_done(o_done[0]));
  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(rst), .tx_data(d_data[1]), .tx_valid(d_valid[1]),
    .tx_ready(o_ready[1]), .tx_serial(o_serial[1]), .tx_busy(o_busy[1]), .tx_done(o_done[1]));
  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset(rst), .tx_data(d_data[2]), .tx_valid(d_valid[2]),
    .tx_ready(o_ready[2]), .tx_serial(o_serial[2]), .tx_busy(o_busy[2]), .tx_done(o_done[2]));
  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .reset(rst), .tx_data(d_data[3]), .tx_valid(d_valid[3]),
    .tx_ready(o_ready[3]), .tx_serial(o_serial[3]), .tx_busy(o_busy[3]), .tx_done(o_done[3]));
  uart_transmitter #(.CLKS_PER_BIT(3), .DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut4 (
    .clk(clk), .reset(rst), .tx_data(d_data[4][4:0]), .tx_valid(d_valid[4]),
    .tx_ready(o_ready[4]), .tx_serial(o_serial[4]), .tx_busy(o_busy[4]), .tx_done(o_done[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] frame_of(input int i, input logic [7:0] d);
    logic [15:0] f;
    int          n;
    logic        p;
    f = '0;
    n = 1;
    p = (PODD[i] != 0);
    for (int b = 0; b < DB[i]; b++) begin
      f[n] = d[b];
      p    = p ^ d[b];
      n++;
    end
    if (PEN[i] != 0) begin
      f[n] = p;
      n++;
    end
    for (int s = 0; s < SB[i]; s++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  function automatic int flen(input int i);
    return (1 + DB[i] + PEN[i] + SB[i]) * CPB[i];
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", nm, idx, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_pos[i]  <= 0;
        m_f[i]    <= '0;
        acc[i]    <= 0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          if (m_pos[i] + 1 == flen(i)) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
          end
          m_pos[i] <= m_pos[i] + 1;
        end else if (d_valid[i]) begin
          m_f[i]    <= frame_of(i, d_data[i]);
          m_pos[i]  <= 0;
          m_busy[i] <= 1'b1;
          acc[i]    <= acc[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_s;
    if (chk_en && !rst) begin
      for (int i = 0; i < N; i++) begin
        e_s = m_busy[i] ? m_f[i][m_pos[i] / CPB[i]] : 1'b1;
        chk("serial", i, 32'(o_serial[i]), 32'(e_s));
        chk("busy",   i, 32'(o_busy[i]),   32'(m_busy[i]));
        chk("ready",  i, 32'(o_ready[i]),  32'(!m_busy[i]));
        chk("done",   i, 32'(o_done[i]),   32'(m_done[i]));
      end
    end
  end

  task automatic send(input int i, input logic [7:0] b);
    int a0;
    bit ok;
    @(posedge clk);
    #1;
    d_data[i]  = b;
    d_valid[i] = 1'b1;
    a0 = acc[i];
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (acc[i] != a0) ok = 1'b1;
    end
    d_valid[i] = 1'b0;
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL handshake_timeout dut%0d t=%0t actual=none expected=transfer", i, $time);
    end
  endtask

  // Samples each bit at its centre; cycle 1 is the first cycle after the handshake edge.
  task automatic capture(input int i, input int ncyc, input int poke,
                         output logic [15:0] bits, output int busy_n, output int done_at);
    bits    = '0;
    busy_n  = 0;
    done_at = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (poke > 0 && c == poke) begin
        d_valid[i] = 1'b1;
        d_data[i]  = 8'h3C;
      end
      if (poke > 0 && c == poke + 1) d_valid[i] = 1'b0;
      if (poke > 0 && c == poke + 10) d_data[i] = 8'($urandom);
      if ((c - 1) % CPB[i] == CPB[i] / 2 && (c - 1) / CPB[i] < 16) bits[(c - 1) / CPB[i]] = o_serial[i];
      if (o_busy[i]) busy_n++;
      if (o_done[i] && done_at == 0) done_at = c;
    end
  endtask

  task automatic drive_rand(input int i, input int ncyc);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (!m_busy[i]) d_valid[i] = ($urandom_range(0, 2) == 0);
      else            d_valid[i] = ($urandom_range(0, 3) == 0);
      d_data[i] = 8'($urandom);
    end
    @(posedge clk);
    #1;
    d_valid[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bits;
    int          busy_n, done_at, a0, hi_run, cnt;
    logic        line [100];
    logic        bz   [100];
    logic        dn   [100];
    logic [7:0]  b1, b2;

    n_chk  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < N; i++) begin
      d_valid[i] = 1'b0;
      d_data[i]  = 8'h00;
    end

    // Reset asserted between clock edges must take effect without any edge.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_serial", i, 32'(o_serial[i]), 32'd1);
      chk("rst_ready",  i, 32'(o_ready[i]),  32'd1);
      chk("rst_busy",   i, 32'(o_busy[i]),   32'd0);
      chk("rst_done",   i, 32'(o_done[i]),   32'd0);
    end
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 8'hA5);
    capture(0, 41, 0, bits, busy_n, done_at);
    chk("a5_bits", 0, 32'(bits), 32'h034A);
    chk("a5_busy_cycles", 0, busy_n, 40);
    chk("a5_done_cycle", 0, done_at, 41);

    send(1, 8'hA5);
    capture(1, 45, 0, bits, busy_n, done_at);
    chk("even_a5_frame", 1, 32'(bits), 32'h054A);
    chk("even_a5_parity", 1, 32'(bits[9]), 32'd0);
    chk("even_a5_busy", 1, busy_n, 44);
    chk("even_a5_done", 1, done_at, 45);

    send(1, 8'h07);
    capture(1, 45, 0, bits, busy_n, done_at);
    chk("even_07_frame", 1, 32'(bits), 32'h060E);
    chk("even_07_parity", 1, 32'(bits[9]), 32'd1);

    send(2, 8'h07);
    capture(2, 45, 0, bits, busy_n, done_at);
    chk("odd_07_frame", 2, 32'(bits), 32'h040E);
    chk("odd_07_parity", 2, 32'(bits[9]), 32'd0);
    chk("odd_07_busy", 2, busy_n, 44);

    send(0, 8'hC3);
    capture(0, 41, 10, bits, busy_n, done_at);
    chk("reject_bits", 0, 32'(bits), 32'h0386);
    chk("reject_busy", 0, busy_n, 40);
    chk("reject_done", 0, done_at, 41);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy[0]) cnt++;
    end
    chk("reject_no_second_frame", 0, cnt, 0);

    // Back-to-back with two stop bits: tx_valid held across the tx_done cycle.
    @(negedge clk);
    d_data[3]  = 8'h00;
    d_valid[3] = 1'b1;
    a0 = acc[3];
    for (int c = 0; c < 95; c++) begin
      @(negedge clk);
      line[c] = o_serial[3];
      bz[c]   = o_busy[3];
      dn[c]   = o_done[3];
      if (acc[3] == a0 + 1) d_data[3] = 8'hFF;
      if (acc[3] >= a0 + 2) d_valid[3] = 1'b0;
    end
    d_valid[3] = 1'b0;
    hi_run = 0;
    for (int c = 36; c < 95 && line[c]; c++) hi_run++;
    for (int k = 0; k < 8; k++) begin
      b1[k] = line[4 * (k + 1) + 2];
      b2[k] = line[45 + 4 * (k + 1) + 2];
    end
    chk("b2b_done_cycle", 3, 32'(dn[44]), 32'd1);
    chk("b2b_idle_gap", 3, 32'(bz[44]), 32'd0);
    chk("b2b_second_start", 3, 32'({bz[45], line[45]}), 32'b10);
    chk("b2b_high_run", 3, hi_run, 9);
    chk("b2b_frame1_data", 3, 32'(b1), 32'h00);
    chk("b2b_frame2_data", 3, 32'(b2), 32'hFF);
    chk("b2b_transfers", 3, acc[3] - a0, 2);

    // Reset during data bit 3 (cycles 17..20); bit 3 of 0x55 is 0, so the line visibly returns high.
    send(0, 8'h55);
    repeat (17) @(posedge clk);
    #1;
    chk("mid_bit3_low", 0, 32'(o_serial[0]), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_serial", 0, 32'(o_serial[0]), 32'd1);
    chk("midrst_busy",   0, 32'(o_busy[0]),   32'd0);
    chk("midrst_ready",  0, 32'(o_ready[0]),  32'd1);
    chk("midrst_done",   0, 32'(o_done[0]),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_done[0]) cnt++;
    end
    chk("midrst_no_done", 0, cnt, 0);
    send(0, 8'h81);
    capture(0, 41, 0, bits, busy_n, done_at);
    chk("after_rst_bits", 0, 32'(bits), 32'h0302);
    chk("after_rst_busy", 0, busy_n, 40);
    chk("after_rst_done", 0, done_at, 41);

    fork
      drive_rand(0, 2000);
      drive_rand(1, 2000);
      drive_rand(2, 2000);
      drive_rand(3, 2000);
      drive_rand(4, 2000);
    join
    repeat (80) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
